usb_rx_fifo: RTL and testbench
==============================

Name: usb_rx_fifo

Overview:
Byte FIFO between the USB CDC receive endpoint and the JTAG command bridge. It absorbs USB bulk bursts so the bridge can consume command bytes at its own rate. It presents a first-word-fall-through valid/ready stream downstream, and reports fill level and back-pressure status for debug and LED use.

Parameters:
DEPTH, 64, number of byte entries; power of two, minimum 2.
ADDR_W, $clog2(DEPTH), pointer index width; derived, not to be overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_i  input  1  asynchronous, active-high reset.
in_data_i  input  8  byte from the USB receive endpoint.
in_valid_i  input  1  in_data_i is valid.
in_ready_o  output  1  FIFO accepts a byte this cycle.
out_data_o  output  8  head byte towards the bridge.
out_valid_o  output  1  out_data_o is valid.
out_ready_i  input  1  bridge consumes the head byte this cycle.
flush_i  input  1  synchronous clear of contents.
level_o  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
empty_o  output  1  level_o == 0.
full_o  output  1  level_o == DEPTH.
backpressure_o  output  1  sticky; set when in_valid_i is high while full.

Behaviour:
- Reset (rst_i high, asynchronous, any time including mid-burst):
  - Pointers and level are 0.
  - in_ready_o = 1, out_valid_o = 0, out_data_o = 8'h00.
  - empty_o = 1, full_o = 0, backpressure_o = 0.
  - Stored contents are discarded.
- Storage: DEPTH x 8 register array. Write and read pointers are ADDR_W+1 bits wide. The index is the low ADDR_W bits; the MSB distinguishes full from empty. Pointers wrap from DEPTH-1 to 0 naturally.
- Status outputs:
  - in_ready_o = !full_o (combinational from registered state).
  - out_valid_o = !empty_o.
  - out_data_o = mem[rd_ptr index], combinational read of registered storage.
- Write: on a clk edge with in_valid_i && in_ready_o, store in_data_i at the write pointer index and increment the write pointer.
- Read: on a clk edge with out_valid_o && out_ready_i, increment the read pointer.
- Latency: a byte written at edge N is visible on out_data_o with out_valid_o high after edge N. This gives one cycle of latency, with no combinational in-to-out bypass when empty.
- Simultaneous write and read (non-empty, non-full): both occur and the level is unchanged.
- Full: in_ready_o = 0. A write is refused even if a read occurs in the same cycle. Upstream must hold the byte, and it is accepted the next cycle.
- Empty: out_valid_o = 0. out_ready_i is ignored and the read pointer does not move.
- level_o = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1). Full is detected when the indices are equal and the MSBs differ.
- backpressure_o:
  - Set on any edge where in_valid_i && full_o.
  - Cleared only by rst_i or flush_i.
  - Flush has priority over a same-cycle set.
- flush_i (synchronous, highest priority):
  - Pointers are set to 0 and level to 0, and backpressure_o is cleared.
  - A same-cycle write and read are both ignored.
  - in_ready_o is 1 from the next cycle.
- out_data_o when empty is don't-care. Verification must not check it while out_valid_o = 0.
- No byte is ever lost or duplicated. Output order equals input order across pointer wrap.

Test Plan:
1. Reset then write "B","R","7" with out_ready_i = 0 -> level_o = 3; out_data_o = 8'h42 with out_valid_o = 1 one cycle after the first write. Then raise out_ready_i -> the bridge receives 8'h42, 8'h52, 8'h37 on three consecutive cycles, and empty_o = 1 afterwards.
2. Fill with DEPTH bytes 0..63 with out_ready_i = 0 -> full_o = 1, in_ready_o = 0, level_o = 64. Hold in_valid_i high with 8'hAA -> backpressure_o = 1 and the byte is not stored. Pop one -> 8'hAA is accepted the following cycle. Drain all -> sequence 0..63 then 8'hAA.
3. Continuous streaming with in_valid_i = out_ready_i = 1 for 200 bytes (pointer wrap three times) -> level_o stays at 1 after the first cycle and the output sequence equals the input sequence.
4. 10 bytes stored and backpressure_o = 1; assert flush_i together with in_valid_i and out_ready_i -> next cycle level_o = 0, empty_o = 1, backpressure_o = 0, and neither byte is written nor popped.
5. Assert rst_i asynchronously between clock edges while half full -> outputs take their reset values immediately, without waiting for a clock edge. After release, a new byte 8'h30 emerges first and no stale data appears.
6. Empty FIFO with out_ready_i = 1 and no input for 20 cycles -> out_valid_o = 0 throughout and the pointers do not move (level_o = 0, not underflowed).

Source files
------------

// File: rtl/usb_rx_fifo.sv
// Byte FIFO between the USB CDC receive endpoint and the JTAG command bridge.
// First-word-fall-through output stream with fill level and sticky back-pressure status.
module usb_rx_fifo #(
    parameter int DEPTH = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [7:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    output logic [ADDR_W:0]   level_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              backpressure_o
);

    // Handshake: a byte moves on a rising edge only when valid and ready are both
    // high on that edge; a producer holds its data stable until that edge occurs.
    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            do_write;
    logic            do_read;

    // Equal indices with differing wrap bits means the writer is one lap ahead.
    assign full_o      = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                         (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign empty_o     = (wr_ptr == rd_ptr);
    assign level_o     = wr_ptr - rd_ptr;
    assign in_ready_o  = !full_o;
    assign out_valid_o = !empty_o;
    assign out_data_o  = empty_o ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];

    assign do_write = in_valid_i && in_ready_o && !flush_i;
    assign do_read  = out_valid_o && out_ready_i && !flush_i;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            backpressure_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            backpressure_o <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_valid_i && full_o) begin
                backpressure_o <= 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is visible until the write pointer moves past it.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_usb_rx_fifo.sv
// Directed bench for usb_rx_fifo: one task per scenario, inline comparisons,
// inputs driven and outputs sampled on the falling clock edge.
module tb_usb_rx_fifo;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rst_i;
    logic [7:0]      in_data_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [7:0]      out_data_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic            flush_i;
    logic [ADDR_W:0] level_o;
    logic            empty_o;
    logic            full_o;
    logic            backpressure_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    usb_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .flush_i        (flush_i),
        .level_o        (level_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .backpressure_o (backpressure_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_data_i = 8'h00; in_valid_i = 1'b0;
        out_ready_i = 1'b0; flush_i = 1'b0;
        repeat (3) tick();
        total++;
        if (level_o !== 7'd0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
            in_ready_o !== 1'b1 || out_valid_o !== 1'b0 ||
            out_data_o !== 8'h00 || backpressure_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: level=%0d empty=%b full=%b in_ready=%b out_valid=%b data=%h bp=%b, want 0 1 0 1 0 00 0",
                     level_o, empty_o, full_o, in_ready_o, out_valid_o, out_data_o, backpressure_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_brs();
        logic [7:0] msg [3];
        msg[0] = 8'h42; msg[1] = 8'h52; msg[2] = 8'h37;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_data_i = msg[i];
            tick();
            if (i == 0) begin
                total++;
                if (out_valid_o !== 1'b1 || out_data_o !== 8'h42) begin
                    bad++;
                    $display("FAIL brs_first_latency: valid=%b data=%h, want 1 42", out_valid_o, out_data_o);
                end
            end
        end
        in_valid_i = 1'b0;
        total++;
        if (level_o !== 7'd3) begin
            bad++;
            $display("FAIL brs_level: got %0d want 3", level_o);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid_o !== 1'b1 || out_data_o !== msg[i]) begin
                bad++;
                $display("FAIL brs_pop%0d: valid=%b data=%h want 1 %h", i, out_valid_o, out_data_o, msg[i]);
            end
            tick();
        end
        out_ready_i = 1'b0;
        total++;
        if (empty_o !== 1'b1 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL brs_empty_after: empty=%b valid=%b want 1 0", empty_o, out_valid_o);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'(i);
            tick();
        end
        total++;
        if (full_o !== 1'b1 || in_ready_o !== 1'b0 || level_o !== 7'd64) begin
            bad++;
            $display("FAIL full_flags: full=%b in_ready=%b level=%0d want 1 0 64", full_o, in_ready_o, level_o);
        end
        in_data_i = 8'hAA;
        tick();
        total++;
        if (backpressure_o !== 1'b1 || level_o !== 7'd64) begin
            bad++;
            $display("FAIL full_refuse: bp=%b level=%0d want 1 64", backpressure_o, level_o);
        end
        // pop one while still offering 8'hAA: the write must be refused on this edge
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        total++;
        if (level_o !== 7'd63 || in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_refuse: level=%0d in_ready=%b want 63 1", level_o, in_ready_o);
        end
        tick();
        in_valid_i = 1'b0;
        total++;
        if (level_o !== 7'd64) begin
            bad++;
            $display("FAIL full_accept_held: level=%0d want 64", level_o);
        end
        out_ready_i = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            logic [7:0] want;
            want = (i == DEPTH) ? 8'hAA : 8'(i);
            total++;
            if (out_valid_o !== 1'b1 || out_data_o !== want) begin
                bad++;
                $display("FAIL full_drain%0d: valid=%b data=%h want 1 %h", i, out_valid_o, out_data_o, want);
            end
            tick();
        end
        out_ready_i = 1'b0;
        total++;
        if (empty_o !== 1'b1 || backpressure_o !== 1'b1) begin
            bad++;
            $display("FAIL full_drained: empty=%b bp=%b want 1 1", empty_o, backpressure_o);
        end
    endtask

    task automatic test_stream();
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data_i = 8'(i * 7 + 3);
            exp_q.push_back(in_data_i);
            tick();
            total++;
            if (level_o !== 7'd1 || out_valid_o !== 1'b1 || out_data_o !== exp_q[0]) begin
                bad++;
                $display("FAIL stream%0d: level=%0d valid=%b data=%h want 1 1 %h", i, level_o, out_valid_o, out_data_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        in_valid_i = 1'b0;
        tick();
        out_ready_i = 1'b0;
        total++;
        if (empty_o !== 1'b1) begin
            bad++;
            $display("FAIL stream_end_empty: empty=%b want 1", empty_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'(8'h10 + i);
            tick();
        end
        total++;
        if (level_o !== 7'd10 || backpressure_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre: level=%0d bp=%b want 10 1", level_o, backpressure_o);
        end
        flush_i = 1'b1; in_data_i = 8'h55; out_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        total++;
        if (level_o !== 7'd0 || empty_o !== 1'b1 || backpressure_o !== 1'b0 ||
            in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear: level=%0d empty=%b bp=%b in_ready=%b valid=%b want 0 1 0 1 0",
                     level_o, empty_o, backpressure_o, in_ready_o, out_valid_o);
        end
        tick();
        total++;
        if (level_o !== 7'd0) begin
            bad++;
            $display("FAIL flush_no_write: level=%0d want 0", level_o);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < DEPTH / 2; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'(8'h80 + i);
            tick();
        end
        in_valid_i = 1'b1; in_data_i = 8'hEE;
        // assert reset mid-cycle and look before any clock edge arrives
        #1 rst_i = 1'b1;
        #1;
        total++;
        if (level_o !== 7'd0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
            in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_data_o !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: level=%0d empty=%b full=%b in_ready=%b valid=%b data=%h want 0 1 0 1 0 00",
                     level_o, empty_o, full_o, in_ready_o, out_valid_o, out_data_o);
        end
        in_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        in_valid_i = 1'b1; in_data_i = 8'h30;
        tick();
        in_valid_i = 1'b0;
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'h30 || level_o !== 7'd1) begin
            bad++;
            $display("FAIL async_first_byte: valid=%b data=%h level=%0d want 1 30 1", out_valid_o, out_data_o, level_o);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        total++;
        if (empty_o !== 1'b1) begin
            bad++;
            $display("FAIL async_no_stale: empty=%b want 1", empty_o);
        end
    endtask

    task automatic test_empty_idle();
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (out_valid_o !== 1'b0 || level_o !== 7'd0) begin
                bad++;
                $display("FAIL empty_idle%0d: valid=%b level=%0d want 0 0", i, out_valid_o, level_o);
            end
        end
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 8'h5A;
        tick();
        in_valid_i = 1'b0;
        total++;
        if (level_o !== 7'd1 || out_data_o !== 8'h5A) begin
            bad++;
            $display("FAIL empty_then_write: level=%0d data=%h want 1 5a", level_o, out_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_brs();
        test_full();
        test_stream();
        test_flush();
        test_async_reset();
        test_empty_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
